// File: rtl/tdm_demux_5ch_pkg.sv
// Shared constants and state encoding for the TDM link (receiver and transmitter side).
package tdm_demux_5ch_pkg;
  localparam int NUM_CH    = 5;
  localparam int SEL_W     = 3;
  localparam int LAST_SLOT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_gap_timer.sv
// Idle-gap counter: counts enabled cycles, pulses o_expired on the GAP_MAX-th one.
module tdm_gap_timer #(
  parameter int GAP_MAX = 16,
  parameter int GAP_W   = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam bit ENABLED = (GAP_MAX != 0);

  logic [GAP_W-1:0] r_cnt;
  logic [GAP_W-1:0] w_cnt_inc;

  // Compare after increment so the pulse lands on the GAP_MAX-th idle cycle itself.
  assign w_cnt_inc = r_cnt + GAP_W'(1);
  assign o_expired = ENABLED && i_en && !i_clear && (w_cnt_inc == GAP_W'(GAP_MAX));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_expired || !ENABLED) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_cnt_inc;
    end
  end
endmodule

// File: rtl/tdm_demux_5ch.sv
// Serial TDM receiver: collects 5 slot bits per frame into a shadow register and
// publishes them to ch_out atomically when slot 4 arrives.
module tdm_demux_5ch
  import tdm_demux_5ch_pkg::*;
#(
  parameter int GAP_MAX = 16,
  parameter int GAP_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [NUM_CH-1:0] ch_out,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [SEL_W-1:0]  cur_sel
);
  // Input stream has no back-pressure: every cycle with din_valid high carries
  // exactly one slot bit, and sof is only meaningful when din_valid is high.
  state_t            r_state;
  logic [NUM_CH-2:0] r_shadow;
  logic              w_gap_en;
  logic              w_gap_expired;

  assign w_gap_en = (r_state == ST_RECV) && !din_valid;
  assign busy     = (r_state == ST_RECV);

  tdm_gap_timer #(
    .GAP_MAX (GAP_MAX),
    .GAP_W   (GAP_W)
  ) u_gap_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (!w_gap_en),
    .i_en      (w_gap_en),
    .o_expired (w_gap_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      ch_out      <= '0;
      cur_sel     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (din_valid) begin
            if (sof) begin
              r_shadow[0] <= din;
              cur_sel     <= SEL_W'(1);
              r_state     <= ST_RECV;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (din_valid) begin
            if (sof) begin
              // Early restart: drop the partial frame, the new bit is slot 0.
              frame_err   <= 1'b1;
              r_shadow[0] <= din;
              cur_sel     <= SEL_W'(1);
            end else if (cur_sel == SEL_W'(LAST_SLOT)) begin
              ch_out      <= {din, r_shadow};
              frame_valid <= 1'b1;
              cur_sel     <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_shadow[cur_sel[1:0]] <= din;
              cur_sel                <= cur_sel + SEL_W'(1);
            end
          end else if (w_gap_expired) begin
            frame_err <= 1'b1;
            cur_sel   <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          cur_sel <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tdm_demux_5ch.sv
// Bench for tdm_demux_5ch: directed frames, expected output events queued and
// checked by an independent monitor on the falling edge.
module tb_tdm_demux_5ch;
  logic       clk;
  logic       reset_n;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic [4:0] ch_out;
  logic       frame_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] cur_sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Entry: bit5 = event is frame_err (else frame_valid), bits4:0 = ch_out during the pulse.
  logic [5:0] exp_q[$];

  tdm_demux_5ch #(
    .GAP_MAX (4),
    .GAP_W   (5)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .ch_out      (ch_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .cur_sel     (cur_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic s, input logic d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Sends a full frame, value bit k = channel k, slot 0 carries sof.
  task automatic send_frame(input logic [4:0] val);
    for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), val[i]);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && (frame_valid || frame_err)) begin
      if (frame_valid && frame_err) begin
        n_tests++;
        n_fail++;
        $display("FAIL both_pulses: frame_valid and frame_err high together");
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: err=%0b ch_out=%05b with empty queue", frame_err, ch_out);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("event", {2'b00, frame_err, ch_out}, {2'b00, e});
      end
    end
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: bench did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reset_n = 1'b0;
    din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    idle(2);
    check("rst_ch_out", {3'b0, ch_out}, 8'h00);
    check("rst_fv", {7'b0, frame_valid}, 8'h00);
    check("rst_fe", {7'b0, frame_err}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_cur_sel", {5'b0, cur_sel}, 8'h00);
    reset_n = 1'b1;
    idle(1);

    // Basic frame: a=1,b=0,c=1,d=1,e=0
    exp_q.push_back({1'b0, 5'b01101});
    drive(1, 1, 1);
    check("f1_busy", {7'b0, busy}, 8'h01);
    check("f1_sel1", {5'b0, cur_sel}, 8'h01);
    drive(1, 0, 0);
    drive(1, 0, 1);
    drive(1, 0, 1);
    check("f1_sel4", {5'b0, cur_sel}, 8'h04);
    drive(1, 0, 0);
    check("f1_fv", {7'b0, frame_valid}, 8'h01);
    check("f1_ch", {3'b0, ch_out}, 8'h0D);
    idle(1);
    check("f1_fv_low", {7'b0, frame_valid}, 8'h00);
    check("f1_busy_low", {7'b0, busy}, 8'h00);

    // Back-to-back frames, no idle between
    exp_q.push_back({1'b0, 5'b10000});
    exp_q.push_back({1'b0, 5'b11111});
    send_frame(5'b10000);
    check("b2b_fv1", {7'b0, frame_valid}, 8'h01);
    send_frame(5'b11111);
    check("b2b_fv2", {7'b0, frame_valid}, 8'h01);
    check("b2b_ch2", {3'b0, ch_out}, 8'h1F);
    idle(1);

    // Restart at slot 2; restarted frame = 5'b00110
    exp_q.push_back({1'b1, 5'b11111});
    exp_q.push_back({1'b0, 5'b00110});
    drive(1, 1, 1);
    drive(1, 0, 0);
    drive(1, 1, 0);
    check("rs_sel", {5'b0, cur_sel}, 8'h01);
    drive(1, 0, 1);
    drive(1, 0, 1);
    drive(1, 0, 0);
    check("rs_ch_hold", {3'b0, ch_out}, 8'h1F);
    drive(1, 0, 0);
    check("rs_ch_new", {3'b0, ch_out}, 8'h06);
    idle(1);

    // Gap abort: sof + 2 slots then 4 idle cycles
    exp_q.push_back({1'b1, 5'b00110});
    drive(1, 1, 1);
    drive(1, 0, 1);
    drive(1, 0, 1);
    idle(3);
    check("gap3_busy", {7'b0, busy}, 8'h01);
    check("gap3_sel", {5'b0, cur_sel}, 8'h03);
    idle(1);
    check("gap4_fe", {7'b0, frame_err}, 8'h01);
    check("gap4_busy", {7'b0, busy}, 8'h00);
    check("gap4_sel", {5'b0, cur_sel}, 8'h00);
    check("gap4_ch", {3'b0, ch_out}, 8'h06);
    idle(1);

    // Gap of GAP_MAX-1 is tolerated; frame = 5'b01010
    exp_q.push_back({1'b0, 5'b01010});
    drive(1, 1, 0);
    idle(3);
    drive(1, 0, 1);
    drive(1, 0, 0);
    drive(1, 0, 1);
    drive(1, 0, 0);
    check("gap3_ok_ch", {3'b0, ch_out}, 8'h0A);
    idle(1);

    // Stray bit without sof in IDLE
    exp_q.push_back({1'b1, 5'b01010});
    drive(1, 0, 1);
    check("stray_fe", {7'b0, frame_err}, 8'h01);
    check("stray_busy", {7'b0, busy}, 8'h00);
    idle(1);

    // Reset during slot 3, then a clean frame 5'b10101
    drive(1, 1, 0);
    drive(1, 0, 1);
    drive(1, 0, 1);
    reset_n = 1'b0;
    drive(1, 0, 1);
    check("mrst_ch", {3'b0, ch_out}, 8'h00);
    check("mrst_busy", {7'b0, busy}, 8'h00);
    check("mrst_sel", {5'b0, cur_sel}, 8'h00);
    check("mrst_fe", {7'b0, frame_err}, 8'h00);
    reset_n = 1'b1;
    exp_q.push_back({1'b0, 5'b10101});
    send_frame(5'b10101);
    check("post_rst_ch", {3'b0, ch_out}, 8'h15);
    idle(3);

    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
